// File: rtl/busy_gnt_pkg.sv
// Shared types and parameter defaults for the busy/grant responder.
// The state encoding is the contract between the FSM and anything that observes it.
package busy_gnt_pkg;

    localparam int DEF_BUSY_COUNT = 3;
    localparam int DEF_GAP        = 1;
    localparam int DEF_GNT_DELAY  = 0;
    localparam int DEF_MAX_PEND   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_PULSE = 3'd2,
        ST_GWAIT = 3'd3,
        ST_GRANT = 3'd4
    } state_e;

    // Index of the last cycle of an n-cycle phase; a zero-length phase maps to 0.
    function automatic logic [3:0] last_idx(input int n);
        return (n > 0) ? 4'(n - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/busy_gnt_pend_ctr.sv
// Saturating pending-request counter with a sticky overflow flag.
// A simultaneous inc and dec cancel, so a full counter never drops a request in that case.
module busy_gnt_pend_ctr
    import busy_gnt_pkg::*;
#(
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       overflow
);

    localparam logic [3:0] MAX_V = 4'(MAX_PEND);

    logic [3:0] count_r;
    logic       overflow_r;

    // Queue depth and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= 4'd0;
            overflow_r <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count_r == MAX_V) begin
                        count_r    <= count_r;
                        overflow_r <= 1'b1;
                    end else begin
                        count_r    <= count_r + 4'd1;
                        overflow_r <= overflow_r;
                    end
                end
                2'b01: begin
                    if (count_r != 4'd0) begin
                        count_r <= count_r - 4'd1;
                    end else begin
                        count_r <= count_r;
                    end
                    overflow_r <= overflow_r;
                end
                default: begin
                    count_r    <= count_r;
                    overflow_r <= overflow_r;
                end
            endcase
        end
    end

    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/busy_gnt_responder.sv
// Responder that answers each request with BUSY_COUNT busy pulses and then one gnt,
// serving queued requests back-to-back and strictly in arrival order.
module busy_gnt_responder
    import busy_gnt_pkg::*;
#(
    parameter int BUSY_COUNT = DEF_BUSY_COUNT,
    parameter int GAP        = DEF_GAP,
    parameter int GNT_DELAY  = DEF_GNT_DELAY,
    parameter int MAX_PEND   = DEF_MAX_PEND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       busy,
    output logic       gnt,
    output logic [3:0] pend_cnt,
    output logic       overflow,
    output logic       active
);

    localparam logic [3:0] GAP_LAST   = last_idx(GAP);
    localparam logic [3:0] GWAIT_LAST = last_idx(GNT_DELAY);
    localparam logic [3:0] PULSE_LAST = last_idx(BUSY_COUNT);

    state_e     state_r;
    state_e     next_state_s;
    logic [3:0] timer_r;
    logic [3:0] pulse_r;
    logic       owe_r;
    logic       inc_s;
    logic       dec_s;
    logic [3:0] pend_cnt_s;
    logic       overflow_s;
    logic       busy_nxt_s;
    logic       gnt_nxt_s;
    logic       active_nxt_s;
    logic       busy_r;
    logic       gnt_r;
    logic       active_r;

    // State register plus phase timer and pulse counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= 4'd0;
            pulse_r <= 4'd0;
            owe_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if ((next_state_s != state_r) || ((state_r != ST_GAP) && (state_r != ST_GWAIT))) begin
                timer_r <= 4'd0;
            end else begin
                timer_r <= timer_r + 4'd1;
            end
            if ((next_state_s == ST_GAP) && ((state_r == ST_IDLE) || (state_r == ST_GRANT))) begin
                pulse_r <= 4'd0;
            end else if (state_r == ST_PULSE) begin
                pulse_r <= pulse_r + 4'd1;
            end else begin
                pulse_r <= pulse_r;
            end
            // A req caught in GRANT with an empty queue starts the next run at once; its queue slot is released a cycle later.
            owe_r <= (state_r == ST_GRANT) && (pend_cnt_s == 4'd0) && req;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) next_state_s = ST_GAP;
                else     next_state_s = ST_IDLE;
            end
            ST_GAP: begin
                if (timer_r == GAP_LAST) next_state_s = ST_PULSE;
                else                     next_state_s = ST_GAP;
            end
            ST_PULSE: begin
                if (pulse_r != PULSE_LAST) next_state_s = ST_GAP;
                else if (GNT_DELAY > 0)    next_state_s = ST_GWAIT;
                else                       next_state_s = ST_GRANT;
            end
            ST_GWAIT: begin
                if (timer_r == GWAIT_LAST) next_state_s = ST_GRANT;
                else                       next_state_s = ST_GWAIT;
            end
            ST_GRANT: begin
                if ((pend_cnt_s != 4'd0) || req) next_state_s = ST_GAP;
                else                             next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, plus queue control
    always_comb begin
        busy_nxt_s   = (next_state_s == ST_PULSE);
        gnt_nxt_s    = (next_state_s == ST_GRANT);
        active_nxt_s = (next_state_s != ST_IDLE);
        inc_s        = req && (state_r != ST_IDLE);
        dec_s        = ((state_r == ST_GRANT) && (pend_cnt_s != 4'd0)) || owe_r;
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            gnt_r    <= 1'b0;
            active_r <= 1'b0;
        end else begin
            busy_r   <= busy_nxt_s;
            gnt_r    <= gnt_nxt_s;
            active_r <= active_nxt_s;
        end
    end

    busy_gnt_pend_ctr #(
        .MAX_PEND (MAX_PEND)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_s),
        .dec      (dec_s),
        .count    (pend_cnt_s),
        .overflow (overflow_s)
    );

    assign busy     = busy_r;
    assign gnt      = gnt_r;
    assign active   = active_r;
    assign pend_cnt = pend_cnt_s;
    assign overflow = overflow_s;

endmodule

// File: tb/tb_busy_gnt_responder.sv
// Table-driven scoreboard bench for busy_gnt_responder, with a second instance
// covering the stretched-gap / delayed-grant configuration.
module tb_busy_gnt_responder;

    localparam int NCYC = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       busy, gnt, overflow, active;
    logic [3:0] pend_cnt;

    logic       rst2 = 1'b1;
    logic       req2 = 1'b0;
    logic       busy2, gnt2, overflow2, active2;
    logic [3:0] pend_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    busy_gnt_responder dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .busy     (busy),
        .gnt      (gnt),
        .pend_cnt (pend_cnt),
        .overflow (overflow),
        .active   (active)
    );

    busy_gnt_responder #(.GAP(2), .GNT_DELAY(2)) dut2 (
        .clk      (clk),
        .rst      (rst2),
        .req      (req2),
        .busy     (busy2),
        .gnt      (gnt2),
        .pend_cnt (pend_cnt2),
        .overflow (overflow2),
        .active   (active2)
    );

    // Initiator-side sequence for the default instance (BUSY_COUNT=3, GAP=1, GNT_DELAY=0)
    a_req_seq: assert property (@(posedge clk) disable iff (rst)
        (req && !active) |=> (!busy ##1 busy ##1 !busy ##1 busy ##1 !busy ##1 busy ##1 gnt))
        else $error("FAIL req_seq: busy/gnt sequence broken");
    a_gnt_after_busy: assert property (@(posedge clk) disable iff (rst) gnt |-> $past(busy))
        else $error("FAIL gnt_after_busy: gnt without busy in previous cycle");
    a_exclusive: assert property (@(posedge clk) disable iff (rst) !(busy && gnt))
        else $error("FAIL exclusive: busy and gnt both high");

    typedef struct {
        int          id;
        logic [39:0] req_m;
        logic [39:0] rst_m;
        logic [39:0] busy_m;
        logic [39:0] gnt_m;
        logic [39:0] act_m;
        logic [39:0] ovf_m;
        logic [3:0]  pend_a [NCYC];
    } scen_t;

    typedef struct packed {
        logic       busy;
        logic       gnt;
        logic       active;
        logic       ovf;
        logic [3:0] pend;
    } exp_t;

    scen_t tbl [5];
    exp_t  sb_q [$];

    function automatic logic [39:0] b(input int n);
        logic [39:0] one;
        one = 40'd1;
        return one << n;
    endfunction

    function automatic logic [39:0] rng(input int lo, input int hi);
        logic [39:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic set_pend(input int s, input int lo, input int hi, input logic [3:0] v);
        for (int i = lo; i <= hi; i++) tbl[s].pend_a[i] = v;
    endtask

    task automatic chk(input string nm, input int id, input int cyc, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s scen %0d cycle %0d: got %0h expected %0h", nm, id, cyc, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        exp_t g;

        for (int s = 0; s < 5; s++) begin
            tbl[s].rst_m = rng(0, 1);
            tbl[s].ovf_m = '0;
            for (int i = 0; i < NCYC; i++) tbl[s].pend_a[i] = 4'd0;
        end
        // single request
        tbl[0].id = 37; tbl[0].req_m = b(5);
        tbl[0].busy_m = b(7) | b(9) | b(11); tbl[0].gnt_m = b(12); tbl[0].act_m = rng(6, 12);
        // second request queued during the run
        tbl[1].id = 39; tbl[1].req_m = b(5) | b(8);
        tbl[1].busy_m = b(7) | b(9) | b(11) | b(14) | b(16) | b(18);
        tbl[1].gnt_m = b(12) | b(19); tbl[1].act_m = rng(6, 19);
        set_pend(1, 9, 12, 4'd1);
        // request in the GRANT cycle with an empty queue
        tbl[2].id = 41; tbl[2].req_m = b(5) | b(12);
        tbl[2].busy_m = tbl[1].busy_m; tbl[2].gnt_m = tbl[1].gnt_m; tbl[2].act_m = rng(6, 19);
        set_pend(2, 13, 13, 4'd1);
        // queue saturation and overflow
        tbl[3].id = 40; tbl[3].req_m = rng(5, 9);
        tbl[3].busy_m = b(7) | b(9) | b(11) | b(14) | b(16) | b(18) | b(21) | b(23) | b(25) | b(28) | b(30) | b(32);
        tbl[3].gnt_m = b(12) | b(19) | b(26) | b(33); tbl[3].act_m = rng(6, 33);
        tbl[3].ovf_m = rng(10, 39);
        set_pend(3, 7, 7, 4'd1); set_pend(3, 8, 8, 4'd2); set_pend(3, 9, 12, 4'd3);
        set_pend(3, 13, 19, 4'd2); set_pend(3, 20, 26, 4'd1);
        // reset mid-run drops the queue; req together with rst is ignored
        tbl[4].id = 42; tbl[4].req_m = b(5) | b(8) | b(9) | b(12); tbl[4].rst_m = rng(0, 1) | b(9);
        tbl[4].busy_m = b(7) | b(9) | b(14) | b(16) | b(18); tbl[4].gnt_m = b(19);
        tbl[4].act_m = rng(6, 9) | rng(13, 19);
        set_pend(4, 9, 9, 4'd1);

        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < NCYC - 1; c++) begin
                req = tbl[s].req_m[c];
                rst = tbl[s].rst_m[c];
                e.busy   = tbl[s].busy_m[c + 1];
                e.gnt    = tbl[s].gnt_m[c + 1];
                e.active = tbl[s].act_m[c + 1];
                e.ovf    = tbl[s].ovf_m[c + 1];
                e.pend   = tbl[s].pend_a[c + 1];
                sb_q.push_back(e);
                @(posedge clk);
                #1;
                g = sb_q.pop_front();
                chk("busy",     tbl[s].id, c + 1, {3'd0, busy},     {3'd0, g.busy});
                chk("gnt",      tbl[s].id, c + 1, {3'd0, gnt},      {3'd0, g.gnt});
                chk("active",   tbl[s].id, c + 1, {3'd0, active},   {3'd0, g.active});
                chk("overflow", tbl[s].id, c + 1, {3'd0, overflow}, {3'd0, g.ovf});
                chk("pend_cnt", tbl[s].id, c + 1, pend_cnt,         g.pend);
            end
        end
        rst = 1'b0;
        req = 1'b0;

        // GAP=2, GNT_DELAY=2: busy at 8, 11, 14 and gnt at 17
        for (int c = 0; c < 24; c++) begin
            rst2 = (c < 2);
            req2 = (c == 5);
            @(posedge clk);
            #1;
            chk("busy2",   38, c + 1, {3'd0, busy2},   {3'd0, ((c + 1) == 8) || ((c + 1) == 11) || ((c + 1) == 14)});
            chk("gnt2",    38, c + 1, {3'd0, gnt2},    {3'd0, ((c + 1) == 17)});
            chk("active2", 38, c + 1, {3'd0, active2}, {3'd0, ((c + 1) >= 6) && ((c + 1) <= 17)});
            chk("pend2",   38, c + 1, pend_cnt2,       4'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
